// File: rtl/pipe_pkg.sv
// Types and sizes shared by the pipeline stage registers, the hazard unit and
// the writeback/register-file block.
package pipe_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: the hardwired-zero check, the write-through
// bypass and the array select.
module regfile_read_port #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs_i,
  input  logic                                 byp_en_i,
  input  logic [ADDR_W-1:0]                    byp_addr_i,
  input  logic [DATA_W-1:0]                    byp_data_i,
  output logic [DATA_W-1:0]                    data_o
);
  import pipe_pkg::*;

  localparam bit BYP_ON = (BYPASS != 0);

  // Zero check has the last word so r0 stays 0 even when a bypass matches it.
  always_comb begin
    data_o = regs_i[addr_i];
    if (BYP_ON && byp_en_i && (addr_i == byp_addr_i))
      data_o = byp_data_i;
    if (addr_i == ADDR_W'(REG_ZERO))
      data_o = '0;
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, architectural register file commit, two
// bypassed read ports and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] ResultW,
  output logic [31:0]       RetireCount
);
  import pipe_pkg::*;

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [31:0]                  retire_q, retire_d;
  logic                         commit;
  logic                         byp_en;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // RegWriteW gates first so X on the index/data while idle cannot leak in.
  assign commit = RegWriteW && (WriteRegW != ADDR_W'(REG_ZERO));
  assign byp_en = commit && !rst;

  always_comb begin
    regs_d   = regs_q;
    retire_d = retire_q;
    if (commit) begin
      regs_d[WriteRegW] = ResultW;
      retire_d          = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      retire_q <= '0;
    end else begin
      regs_q   <= regs_d;
      retire_q <= retire_d;
    end
  end

  assign RetireCount = retire_q;

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp1 (
    .addr_i     (A1),
    .regs_i     (regs_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (WriteRegW),
    .byp_data_i (ResultW),
    .data_o     (RD1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp2 (
    .addr_i     (A2),
    .regs_i     (regs_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (WriteRegW),
    .byp_data_i (ResultW),
    .data_o     (RD2)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed checks of wb_regfile with bypass on (u_dut) and off (u_nb) sharing
// the same stimulus.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  WriteRegW, A1, A2;
  logic [31:0] ALUOutW, ReadDataW;
  logic [31:0] RD1, RD2, ResultW, RetireCount;
  logic [31:0] nb_RD1, nb_RD2, nb_ResultW, nb_RetireCount;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .WriteRegW(WriteRegW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
    .RetireCount(RetireCount)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .WriteRegW(WriteRegW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .A1(A1), .A2(A2), .RD1(nb_RD1), .RD2(nb_RD2), .ResultW(nb_ResultW),
    .RetireCount(nb_RetireCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle inputs/outputs 1ns later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = idx; ALUOutW = val;
    step();
    RegWriteW = 1'b0;
  endtask

  initial begin
    rst = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0; WriteRegW = '0;
    ALUOutW = '0; ReadDataW = '0; A1 = '0; A2 = '0;
    #1;
    step(); step();
    rst = 1'b0;
    #1;

    // reset then idle
    chk("rst_cnt", RetireCount, 32'd0);
    chk("rst_cnt_nb", nb_RetireCount, 32'd0);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd1_%0d", i), RD1, 32'd0);
      chk($sformatf("rst_rd2_%0d", 31 - i), RD2, 32'd0);
    end

    // ALU writeback
    RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = 5'd5;
    ALUOutW = 32'h0000_1234; ReadDataW = 32'hDEAD_BEEF; A1 = 5'd1; A2 = 5'd1;
    #1;
    chk("alu_result", ResultW, 32'h0000_1234);
    step();
    RegWriteW = 1'b0; A1 = 5'd5;
    #1;
    chk("alu_rd1", RD1, 32'h0000_1234);
    chk("alu_rd1_nb", nb_RD1, 32'h0000_1234);
    chk("alu_cnt", RetireCount, 32'd1);

    // load writeback with same-cycle read of the destination
    RegWriteW = 1'b1; MemtoRegW = 1'b1; WriteRegW = 5'd7;
    ALUOutW = 32'h0000_0000; ReadDataW = 32'hCAFE_0001; A1 = 5'd7; A2 = 5'd7;
    #1;
    chk("ld_result", ResultW, 32'hCAFE_0001);
    chk("ld_byp_rd1", RD1, 32'hCAFE_0001);
    chk("ld_byp_rd2", RD2, 32'hCAFE_0001);
    chk("ld_nobyp_rd1", nb_RD1, 32'h0);
    chk("ld_nobyp_rd2", nb_RD2, 32'h0);
    step();
    RegWriteW = 1'b0;
    #1;
    chk("ld_nb_after_rd1", nb_RD1, 32'hCAFE_0001);
    chk("ld_nb_after_rd2", nb_RD2, 32'hCAFE_0001);
    chk("ld_cnt", RetireCount, 32'd2);

    // register 0 protection
    RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = 5'd0;
    ALUOutW = 32'hFFFF_FFFF; A1 = 5'd0; A2 = 5'd0;
    #1;
    chk("r0_result", ResultW, 32'hFFFF_FFFF);
    chk("r0_same_rd1", RD1, 32'h0);
    chk("r0_same_rd2", RD2, 32'h0);
    step();
    RegWriteW = 1'b0;
    #1;
    chk("r0_next_rd1", RD1, 32'h0);
    chk("r0_cnt", RetireCount, 32'd2);

    // disabled write and X-safety, reg 9 preloaded with 9
    wr(5'd9, 32'h0000_0009);
    #1;
    chk("pre9_cnt", RetireCount, 32'd3);
    RegWriteW = 1'b0; WriteRegW = 5'd9; ALUOutW = 32'h55; A1 = 5'd9; A2 = 5'd5;
    #1;
    chk("dis_same_rd1", RD1, 32'h0000_0009);
    step();
    chk("dis_next_rd1", RD1, 32'h0000_0009);
    chk("dis_cnt", RetireCount, 32'd3);
    WriteRegW = 'x; ALUOutW = 'x; ReadDataW = 'x; MemtoRegW = 'x;
    step();
    chk("x_rd1", RD1, 32'h0000_0009);
    chk("x_rd2", RD2, 32'h0000_1234);
    chk("x_cnt", RetireCount, 32'd3);

    // reset collision: write to reg 3 on the reset edge
    rst = 1'b1; RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = 5'd3;
    ALUOutW = 32'h77; ReadDataW = 32'h0; A1 = 5'd3; A2 = 5'd7;
    #1;
    chk("rc_during_rd1", RD1, 32'h0);
    step();
    rst = 1'b0; RegWriteW = 1'b0;
    #1;
    chk("rc_rd1", RD1, 32'h0);
    chk("rc_rd2", RD2, 32'h0);
    chk("rc_cnt", RetireCount, 32'd0);
    A2 = 5'd9;
    #1;
    chk("rc_r9", RD2, 32'h0);

    // back-to-back writes to reg 3
    wr(5'd3, 32'h1);
    #1;
    chk("b2b_cnt1", RetireCount, 32'd1);
    wr(5'd3, 32'h2);
    #1;
    chk("b2b_rd1", RD1, 32'h2);
    chk("b2b_rd1_nb", nb_RD1, 32'h2);
    chk("b2b_cnt", RetireCount, 32'd2);
    chk("b2b_cnt_nb", nb_RetireCount, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result (ALU result or load data) and commits it into the architectural register file.
- Serves the two decode-stage read ports, with write-through bypass so same-cycle reads return the new value.
- Keeps a retired-write counter for debug and performance.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width; register count is 2**ADDR_W
- BYPASS, 1, 1 enables the internal write-to-read bypass; 0 makes reads return the pre-write value

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- RegWriteW  in  1  writeback enable from MEM/WB
- MemtoRegW  in  1  1 selects ReadDataW, 0 selects ALUOutW
- WriteRegW  in  ADDR_W  destination register index
- ALUOutW  in  DATA_W  ALU result from MEM/WB
- ReadDataW  in  DATA_W  load data from MEM/WB
- A1  in  ADDR_W  read port 1 index (decode stage)
- A2  in  ADDR_W  read port 2 index (decode stage)
- RD1  out  DATA_W  read port 1 data
- RD2  out  DATA_W  read port 2 data
- ResultW  out  DATA_W  selected writeback value, also used by the forwarding network
- RetireCount  out  32  number of committed register writes since reset

Behaviour:
- ResultW is combinational: MemtoRegW ? ReadDataW : ALUOutW. It is valid regardless of RegWriteW.
- Commit condition: commit = RegWriteW && (WriteRegW != 0).
- On a clk edge with commit, regs[WriteRegW] <= ResultW.
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including under bypass.
- Reads are combinational: RDn = (An == 0) ? 0 : (BYPASS && commit && An == WriteRegW) ? ResultW : regs[An].
- Latency:
  - A write is visible on RD1/RD2 in the same cycle via bypass when BYPASS=1.
  - With BYPASS=0, the write is visible from the cycle after the commit edge.
- Both ports may read the same index at once; both return identical data.
- RetireCount increments by 1 on each commit edge.
  - It wraps from 0xFFFFFFFF to 0 with no flag.
  - Writes to register 0 do not count.
- Reset, when rst=1 at a clk edge:
  - All registers are cleared to 0.
  - RetireCount is cleared to 0.
  - Any commit in that same cycle is suppressed, because rst has priority.
  - During rst, RD1/RD2 return the stored (cleared) values. Bypass is disabled while rst=1, so RD1/RD2 are never the in-flight ResultW.
- Reset mid-operation: a write pending at the rst edge is lost. The first commit after reset counts as RetireCount=1.
- X-safety: when RegWriteW=0, WriteRegW and the data inputs may be X. State and RetireCount must not change.
- Outputs after reset: RD1=RD2=0 for every index. ResultW follows its inputs and has no reset value. RetireCount=0.

Decomposition:
- Shared package pipe_pkg:
  - Localparams DATA_W, ADDR_W, REG_ZERO=0.
  - Typedefs reg_idx_t (ADDR_W bits) and word_t (DATA_W bits).
  - These are shared with the stage registers and the hazard unit.
- One natural sub-module: regfile_read_port.
  - Purely the zero/bypass/array read mux.
  - Instantiated twice, for A1/RD1 and A2/RD2.
- The writeback mux, storage array and counter stay in the top.

Test Plan:
- Reset then idle: rst high 2 cycles, drop. Read A1=1..31 → all RD=0; RetireCount=0.
- ALU writeback: RegWriteW=1, MemtoRegW=0, WriteRegW=5, ALUOutW=0x0000_1234, ReadDataW=0xDEAD_BEEF → ResultW=0x1234. The next cycle A1=5 gives RD1=0x1234; RetireCount=1.
- Load writeback with same-cycle bypass: RegWriteW=1, MemtoRegW=1, WriteRegW=7, ReadDataW=0xCAFE_0001, A1=A2=7 in the same cycle → RD1=RD2=0xCAFE_0001 before the edge (BYPASS=1). With BYPASS=0, RD1=RD2=old value (0).
- Register 0 protection: RegWriteW=1, WriteRegW=0, ALUOutW=0xFFFF_FFFF; A1=0 → RD1=0 in the same and next cycle; RetireCount unchanged.
- Disabled write: RegWriteW=0, WriteRegW=9, ALUOutW=0x55 → reg 9 remains at its prior value 0x0000_0009 (preloaded); RetireCount unchanged.
- Reset collision: write reg 3 = 0x77 with rst=1 on the same edge → reg 3=0 and RetireCount=0 after the edge. Back-to-back writes to reg 3 (0x1 then 0x2) after reset → RD1=0x2 and RetireCount=2.
